// File: rtl/prim_fifo_burst_reader.sv
// Burst reader for a valid/ready FIFO: pops entries and emits bounded
// bursts with a last marker, starting early on full depth, late on timeout/flush.
// Ports:
//   clk_i, rst_i (async, active-high), clr_i (sync clear), flush_i
//   fifo_rvalid_i, fifo_rready_o, fifo_rdata_i, fifo_depth_i : FIFO read side
//   out_valid_o, out_ready_i, out_data_o, out_last_o         : beat output
//   burst_len_o : length of current burst, busy_o : activity flag
module prim_fifo_burst_reader #(
    parameter int Width         = 16,
    parameter int Depth         = 4,
    parameter int BurstLen      = 4,
    parameter int TimeoutCycles = 16,
    localparam int DepthW = ((Depth + 1) == 1) ? 1 : $clog2(Depth + 1),
    localparam int LenW   = ($clog2(BurstLen + 1) < 1) ? 1
                                                        : $clog2(BurstLen + 1),
    localparam int TimerW = ($clog2(TimeoutCycles) < 1) ? 1
                                                        : $clog2(TimeoutCycles)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              flush_i,
    input  logic              fifo_rvalid_i,
    output logic              fifo_rready_o,
    input  logic [Width-1:0]  fifo_rdata_i,
    input  logic [DepthW-1:0] fifo_depth_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [Width-1:0]  out_data_o,
    output logic              out_last_o,
    output logic [LenW-1:0]   burst_len_o,
    output logic              busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST
    } state_e;

    localparam logic [DepthW-1:0] BurstLenD = DepthW'(BurstLen);
    localparam logic [LenW-1:0]   BurstLenL = LenW'(BurstLen);
    localparam logic [TimerW-1:0] TimerLast = TimerW'(TimeoutCycles - 1);

    state_e             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic [LenW-1:0]    remaining_q, remaining_d;
    logic               out_valid_d;
    logic [Width-1:0]   out_data_d;
    logic               out_last_d;
    logic [LenW-1:0]    burst_len_d;

    logic               depth_full;
    logic [LenW-1:0]    clamp_len;
    logic               pop;
    logic               accept;

    assign depth_full = fifo_depth_i >= BurstLenD;
    // Below BurstLen the depth always fits in LenW bits.
    assign clamp_len  = depth_full ? BurstLenL : LenW'(fifo_depth_i);

    // The output register may be refilled in the same cycle it drains.
    assign pop = (state_q == BURST) && (remaining_q != '0) &&
                 fifo_rvalid_i && (!out_valid_o || out_ready_i);
    assign accept = out_valid_o && out_ready_i;

    assign fifo_rready_o = pop;
    assign busy_o        = (state_q != IDLE) || out_valid_o;

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        remaining_d = remaining_q;
        out_valid_d = out_valid_o;
        out_data_d  = out_data_o;
        out_last_d  = out_last_o;
        burst_len_d = burst_len_o;

        if (clr_i) begin
            state_d     = IDLE;
            timer_d     = '0;
            remaining_d = '0;
            out_valid_d = 1'b0;
            out_data_d  = '0;
            out_last_d  = 1'b0;
            burst_len_d = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (depth_full) begin
                        state_d     = BURST;
                        remaining_d = BurstLenL;
                        burst_len_d = BurstLenL;
                    end else if (fifo_rvalid_i) begin
                        state_d = WAIT;
                        timer_d = '0;
                    end
                end
                WAIT: begin
                    if (depth_full || flush_i || (timer_q == TimerLast)) begin
                        // rvalid with zero depth (pass-through FIFO) has
                        // nothing countable to burst, so give up.
                        if (clamp_len == '0) begin
                            state_d = IDLE;
                        end else begin
                            state_d     = BURST;
                            remaining_d = clamp_len;
                            burst_len_d = clamp_len;
                        end
                    end else begin
                        timer_d = timer_q + TimerW'(1);
                    end
                end
                BURST: begin
                    if (pop) begin
                        out_data_d  = fifo_rdata_i;
                        out_valid_d = 1'b1;
                        out_last_d  = (remaining_q == LenW'(1));
                        remaining_d = remaining_q - LenW'(1);
                    end else if (accept) begin
                        out_valid_d = 1'b0;
                    end
                    // remaining is zero here, so no pop competes.
                    if (accept && out_last_o) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            remaining_q <= '0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_last_o  <= 1'b0;
            burst_len_o <= '0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            remaining_q <= remaining_d;
            out_valid_o <= out_valid_d;
            out_data_o  <= out_data_d;
            out_last_o  <= out_last_d;
            burst_len_o <= burst_len_d;
        end
    end

endmodule
